// File: rtl/debug_seq_sched.sv
// Converts SEQ_NUM signed debug words into sign + hex glyph codes in a double-buffered table.
// Optional macro DEBUG_SEQ_FREEZE_EN adds a freeze input that blocks new frames while idle.
module debug_seq_sched #(
  parameter int unsigned SEQ_LEN    = 16,
  parameter int unsigned SEQ_NUM    = 16,
  parameter int unsigned SEQ_DIGITS = SEQ_LEN / 4 + 1,
  localparam int unsigned IdxW      = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1,
  localparam int unsigned DigW      = (SEQ_DIGITS > 1) ? $clog2(SEQ_DIGITS) : 1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
`ifdef DEBUG_SEQ_FREEZE_EN
  input  logic                       freeze,
`endif
  input  logic                       frame_start,
  input  logic [SEQ_NUM*SEQ_LEN-1:0] seq_flat,
  input  logic [IdxW-1:0]            rd_idx,
  input  logic [DigW-1:0]            rd_digit,
  output logic [4:0]                 rd_code,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 overrun_cnt
);

  typedef enum logic [2:0] {StIdle, StCapture, StLoad, StEmit, StSwap} state_e;
  typedef logic [1:0][SEQ_NUM-1:0][SEQ_DIGITS-1:0][4:0] table_t;

  localparam logic [4:0]      GlyphPlus  = 5'd16;
  localparam logic [4:0]      GlyphMinus = 5'd17;
  localparam logic [IdxW-1:0] IdxLast    = IdxW'(SEQ_NUM - 1);
  localparam logic [DigW-1:0] DigLast    = DigW'(SEQ_DIGITS - 1);

  function automatic table_t init_table();
    table_t t;
    t = '0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < int'(SEQ_NUM); i++) begin
        t[b][i][0] = GlyphPlus;
      end
    end
    return t;
  endfunction

  localparam table_t TableInit = init_table();

  state_e                     state_q, state_d;
  logic [SEQ_NUM*SEQ_LEN-1:0] snap_q, snap_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [DigW-1:0]            dig_q, dig_d;
  logic                       sign_q, sign_d;
  logic [SEQ_LEN-1:0]         mag_q, mag_d;
  logic                       sel_q, sel_d;
  table_t                     bank_q, bank_d;
  logic [7:0]                 ovr_q, ovr_d;

  logic                       start_ok;
  logic [SEQ_LEN-1:0]         cur_seq;
  logic [4:0]                 glyph;

`ifdef DEBUG_SEQ_FREEZE_EN
  assign start_ok = frame_start & ~freeze;
`else
  assign start_ok = frame_start;
`endif

  assign cur_seq     = snap_q[idx_q*SEQ_LEN +: SEQ_LEN];
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StSwap);
  assign overrun_cnt = ovr_q;

  // Front bank is sel_q; out-of-range selects read as '+'.
  always_comb begin
    rd_code = GlyphPlus;
    if (32'(rd_idx) < SEQ_NUM && 32'(rd_digit) < SEQ_DIGITS) begin
      rd_code = bank_q[sel_q][rd_idx][rd_digit];
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    sel_d   = sel_q;
    bank_d  = bank_q;
    ovr_d   = ovr_q;
    glyph   = GlyphPlus;

    if (frame_start && busy && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StCapture;
      end
      StCapture: begin
        snap_d  = seq_flat;
        idx_d   = '0;
        state_d = StLoad;
      end
      StLoad: begin
        sign_d  = cur_seq[SEQ_LEN-1];
        mag_d   = cur_seq[SEQ_LEN-1] ? (~cur_seq + SEQ_LEN'(1)) : cur_seq;
        dig_d   = '0;
        state_d = StEmit;
      end
      StEmit: begin
        // Magnitude shifts left once per hex glyph so the top nibble is always next.
        if (dig_q == '0) begin
          glyph = sign_q ? GlyphMinus : GlyphPlus;
        end else begin
          glyph = {1'b0, mag_q[SEQ_LEN-1 -: 4]};
          mag_d = mag_q << 4;
        end
        bank_d[~sel_q][idx_q][dig_q] = glyph;
        if (dig_q == DigLast) begin
          if (idx_q == IdxLast) begin
            state_d = StSwap;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StLoad;
          end
        end else begin
          dig_d = dig_q + DigW'(1);
        end
      end
      StSwap: begin
        sel_d   = ~sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      sel_q   <= 1'b0;
      bank_q  <= TableInit;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      sel_q   <= sel_d;
      bank_q  <= bank_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_debug_seq_sched.sv
// Scoreboard bench for debug_seq_sched: expected tables and done cycles are queued at each
// accepted frame_start and retired when done pulses.
module tb_debug_seq_sched;

  typedef logic [15:0][24:0] tbl_t;
  typedef struct {
    int   done_cyc;
    tbl_t tbl;
  } exp_t;

  logic         sys_clk;
  logic         sys_rst;
  logic         frame_start;
  logic [255:0] seq_flat;
  logic [3:0]   rd_idx;
  logic [2:0]   rd_digit;
  logic [4:0]   rd_code;
  logic         busy;
  logic         done;
  logic [7:0]   overrun_cnt;
`ifdef DEBUG_SEQ_FREEZE_EN
  logic         freeze;
`endif

  int          n_checks;
  int          n_errors;
  int          exp_ovr;
  int          first_done;
  int          pulse_all_to;
  int          pulses[$];
  exp_t        sb[$];
  tbl_t        exp_front;
  tbl_t        rd_tbl;
  logic [15:0] seq_v[16];

  debug_seq_sched dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
`ifdef DEBUG_SEQ_FREEZE_EN
    .freeze      (freeze),
`endif
    .frame_start (frame_start),
    .seq_flat    (seq_flat),
    .rd_idx      (rd_idx),
    .rd_digit    (rd_digit),
    .rd_code     (rd_code),
    .busy        (busy),
    .done        (done),
    .overrun_cnt (overrun_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] model_seq(input logic [15:0] v);
    logic [15:0] m;
    logic [4:0]  s;
    s = v[15] ? 5'd17 : 5'd16;
    m = v[15] ? (16'd0 - v) : v;
    return {s, 1'b0, m[15:12], 1'b0, m[11:8], 1'b0, m[7:4], 1'b0, m[3:0]};
  endfunction

  function automatic tbl_t init_tbl();
    tbl_t t;
    for (int i = 0; i < 16; i++) t[i] = model_seq(16'h0000);
    return t;
  endfunction

  function automatic tbl_t model_tbl();
    tbl_t t;
    for (int i = 0; i < 16; i++) t[i] = model_seq(seq_v[i]);
    return t;
  endfunction

  function automatic bit freeze_on();
`ifdef DEBUG_SEQ_FREEZE_EN
    return freeze;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit pulse_at(input int c);
    foreach (pulses[k]) if (pulses[k] == c) return 1'b1;
    return (c < pulse_all_to);
  endfunction

  task automatic set_flat();
    for (int i = 0; i < 16; i++) seq_flat[i*16 +: 16] = seq_v[i];
  endtask

  task automatic randomize_seqs();
    for (int i = 0; i < 16; i++) seq_v[i] = 16'($urandom);
    set_flat();
  endtask

  task automatic read_table();
    for (int i = 0; i < 16; i++) begin
      rd_tbl[i] = '0;
      for (int d = 0; d < 5; d++) begin
        rd_idx   = 4'(i);
        rd_digit = 3'(d);
        #1;
        rd_tbl[i] = {rd_tbl[i][19:0], rd_code};
      end
    end
  endtask

  task automatic cmp_table(input string tag);
    read_table();
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_seq%0d", tag, i), rd_tbl[i], exp_front[i]);
    end
  endtask

  task automatic check_range();
    rd_idx = 4'd3;
    for (int d = 5; d < 8; d++) begin
      rd_digit = 3'(d);
      #1;
      check_eq($sformatf("range_digit%0d", d), rd_code, 5'd16);
    end
  endtask

  // Runs ncyc cycles from a fresh edge; rst_cyc/chg_cyc < 0 disable those events.
  task automatic run(input string tag, input int ncyc, input int rst_cyc, input int chg_cyc);
    int   busy_from;
    int   busy_to;
    int   mon_bad;
    int   busy_bad;
    int   done_bad;
    bit   mon_off;
    bit   exp_busy;
    bit   exp_done;
    exp_t e;
    busy_from  = -1;
    busy_to    = -1;
    mon_bad    = 0;
    busy_bad   = 0;
    done_bad   = 0;
    mon_off    = 1'b0;
    first_done = -1;
    rd_idx     = 4'd0;
    rd_digit   = 3'd1;
    @(posedge sys_clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      exp_busy = (c >= busy_from) && (c <= busy_to);
      exp_done = (sb.size() > 0) && (sb[0].done_cyc == c);
      if (busy !== exp_busy) busy_bad++;
      if (done !== exp_done) done_bad++;
      if (!mon_off && rd_code !== exp_front[0][19:15]) mon_bad++;
      if (done === 1'b1 && first_done < 0) first_done = c;
      if (exp_done) begin
        e         = sb.pop_front();
        exp_front = e.tbl;
        mon_off   = 1'b1;
      end
      sys_rst = (c == rst_cyc);
      if (c == chg_cyc) randomize_seqs();
      frame_start = pulse_at(c);
      if (sys_rst) begin
        sb.delete();
        exp_ovr   = 0;
        busy_to   = c;
        exp_front = init_tbl();
        mon_off   = 1'b1;
      end else if (frame_start) begin
        if (c >= busy_from && c <= busy_to) begin
          if (exp_ovr < 255) exp_ovr++;
        end else if (!freeze_on()) begin
          e.done_cyc = c + 98;
          e.tbl      = model_tbl();
          sb.push_back(e);
          busy_from = c + 1;
          busy_to   = c + 98;
        end
      end
      @(posedge sys_clk);
      #1;
    end
    frame_start = 1'b0;
    sys_rst     = 1'b0;
    check_eq({tag, "_busy_trace"}, busy_bad, 0);
    check_eq({tag, "_done_trace"}, done_bad, 0);
    check_eq({tag, "_front_stable"}, mon_bad, 0);
    check_eq({tag, "_pending"}, sb.size(), 0);
    check_eq({tag, "_busy_end"}, busy, 1'b0);
    check_eq({tag, "_overrun"}, overrun_cnt, exp_ovr);
    cmp_table(tag);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    exp_ovr      = 0;
    pulse_all_to = 0;
    sys_rst      = 1'b1;
    frame_start  = 1'b0;
    rd_idx       = 4'd0;
    rd_digit     = 3'd0;
`ifdef DEBUG_SEQ_FREEZE_EN
    freeze       = 1'b0;
`endif
    for (int i = 0; i < 16; i++) seq_v[i] = 16'h0000;
    set_flat();
    exp_front = init_tbl();
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_overrun", overrun_cnt, 8'd0);
    cmp_table("rst");
    check_range();

    randomize_seqs();
    seq_v[0] = 16'h1234;
    seq_v[1] = 16'hFFFF;
    set_flat();
    pulses = '{0};
    run("basic", 120, -1, -1);
    check_eq("latency", first_done, 98);
    check_eq("seq0_1234", rd_tbl[0], {5'd16, 5'd1, 5'd2, 5'd3, 5'd4});
    check_eq("seq1_ffff", rd_tbl[1], {5'd17, 5'd0, 5'd0, 5'd0, 5'd1});
    check_range();

    seq_v[2] = 16'h8000;
    seq_v[3] = 16'h7FFF;
    set_flat();
    run("edge", 120, -1, -1);
    check_eq("seq2_8000", rd_tbl[2], {5'd17, 5'd8, 5'd0, 5'd0, 5'd0});
    check_eq("seq3_7fff", rd_tbl[3], {5'd16, 5'd7, 5'd15, 5'd15, 5'd15});

    randomize_seqs();
    pulses = '{0, 10, 97};
    run("overrun", 120, -1, 5);
    check_eq("overrun_two", overrun_cnt, 8'd2);

    pulses = '{0, 98, 99};
    run("swap_edge", 220, -1, 50);
    check_eq("overrun_three", overrun_cnt, 8'd3);

    pulses = '{0};
    run("reset_mid", 120, 50, -1);
    randomize_seqs();
    run("after_reset", 120, -1, -1);

    pulses.delete();
    pulse_all_to = 300;
    run("saturate", 420, -1, -1);
    pulse_all_to = 0;
    check_eq("overrun_sat", overrun_cnt, 8'd255);

`ifdef DEBUG_SEQ_FREEZE_EN
    freeze = 1'b1;
    randomize_seqs();
    pulses = '{0};
    run("frozen", 120, -1, -1);
    freeze = 1'b0;
    randomize_seqs();
    run("unfrozen", 120, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_seq_sched.md
DEBUG_SEQ_SCHED -- requirements
Module: debug_seq_sched

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter SEQ_LEN, default 16: bit width of each debug sequence; SHALL be a multiple of 4.
REQ-003 Parameter SEQ_NUM, default 16: number of debug sequences.
REQ-004 Parameter SEQ_DIGITS, default SEQ_LEN/4+1: glyphs per sequence, 1 sign plus SEQ_LEN/4 hex.
REQ-005 Ports (name  direction  width  meaning):
- sys_clk  in  1  clock.
- sys_rst  in  1  sync active-high reset.
- frame_start  in  1  single-cycle pulse at start of vertical blank.
- seq_flat  in  SEQ_NUM*SEQ_LEN  packed sequences; seq i = bits [i*SEQ_LEN +: SEQ_LEN], two's complement.
- rd_idx  in  clog2(SEQ_NUM)  sequence select from pixel generator.
- rd_digit  in  clog2(SEQ_DIGITS)  glyph select; 0 = sign, 1 = most-significant hex.
- rd_code  out  5  glyph code: 0-15 hex, 16 '+', 17 '-'.
- busy  out  1  conversion in progress.
- done  out  1  single-cycle pulse on bank swap.
- overrun_cnt  out  8  frame_start pulses dropped while busy.

Function
REQ-006 SHALL use a double-buffered glyph table: front bank for reads, back bank for writes, each SEQ_NUM*SEQ_DIGITS x 5 bits.
REQ-007 rd_code SHALL equal front[rd_idx][rd_digit] combinationally; indices out of range SHALL return 16.
REQ-008 FSM states: IDLE, CAPTURE, LOAD, EMIT, SWAP.
REQ-009 IDLE: on frame_start=1, go to CAPTURE.
REQ-010 CAPTURE (1 cycle): latch all of seq_flat into the snapshot register, set seq index i=0, then go to LOAD.
REQ-011 LOAD (1 cycle): sign = snapshot[i] MSB; magnitude = sign ? (~snapshot[i]+1) : snapshot[i], SEQ_LEN bits unsigned; 0x8000 SHALL yield magnitude 0x8000. Then go to EMIT with digit d=0.
REQ-012 EMIT: write exactly one glyph per cycle into back[i][d]. d=0 writes 17 if sign else 16. d=k>0 writes magnitude nibble (SEQ_LEN/4-k), so the most-significant nibble comes first. After d=SEQ_DIGITS-1: if i<SEQ_NUM-1, increment i and go to LOAD; else go to SWAP.
REQ-013 SWAP (1 cycle): toggle bank select, pulse done=1, return to IDLE; the new front bank is visible on rd_code the next cycle.
REQ-014 Latency from frame_start to done SHALL be exactly 2+SEQ_NUM*(1+SEQ_DIGITS) cycles; 98 with defaults.
REQ-015 busy SHALL be 1 in CAPTURE, LOAD, EMIT and SWAP, and 0 in IDLE.
REQ-016 frame_start while busy=1 SHALL be ignored; overrun_cnt SHALL increment, saturating at 255.
REQ-017 frame_start in the SWAP cycle counts as an overrun; frame_start in the cycle after SWAP (IDLE) SHALL start a new capture.
REQ-018 Input changes to seq_flat after CAPTURE SHALL NOT affect the glyphs of the current conversion.
REQ-019 The front bank SHALL never be written; reads SHALL remain stable for the whole conversion.

Reset
REQ-020 On sys_rst=1: state IDLE, busy=0, done=0, overrun_cnt=0, bank select=0, i=0, d=0.
REQ-021 On sys_rst=1: both banks SHALL initialize to sign glyph 16 and hex glyphs 0, so rd_code reads "+0000".
REQ-022 Reset mid-conversion SHALL abort the conversion with no swap; the table SHALL read "+0000" afterwards.

Configuration
REQ-023 Macro DEBUG_SEQ_FREEZE_EN. When defined, the block SHALL add input freeze (1 bit); frame_start in IDLE with freeze=1 SHALL be ignored, not counted as an overrun, and the front bank held.
REQ-024 When DEBUG_SEQ_FREEZE_EN is undefined, the freeze port SHALL be absent and behaviour SHALL be as REQ-009.

Verification
REQ-025 Reset, then read all indices -> rd_code = 16 at digit 0 and 0 at digits 1-4; busy=0; overrun_cnt=0.
REQ-026 seq0=0x1234, seq1=0xFFFF, frame_start -> done exactly 98 cycles later; seq0 reads 16,1,2,3,4 and seq1 reads 17,0,0,0,1.
REQ-027 seq2=0x8000 and seq3=0x7FFF -> seq2 reads 17,8,0,0,0 and seq3 reads 16,7,F,F,F.
REQ-028 frame_start at cycles 0, 10 and 97 -> one conversion only; overrun_cnt=2; change seq_flat at cycle 5 -> glyphs reflect the cycle-0 value.
REQ-029 sys_rst at cycle 50 of a conversion -> done never pulses; all reads return "+0000"; the next frame_start converts normally.
REQ-030 With DEBUG_SEQ_FREEZE_EN: freeze=1 and frame_start -> busy stays 0, overrun_cnt unchanged, old glyphs held; freeze=0 -> the next frame updates.
